instr_fetch_unit: RTL and testbench

Instruction fetch front end for the microprocessor: it owns the program counter, drives the word address of the single-port instruction memory (32-bit words, 9-bit word address, zero read latency) and presents each fetched word to decode through a valid/ready register stage. It sits between the instruction memory and the decode stage. It also handles branch/jump redirects, back-pressure from decode and misaligned redirect targets.

---
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end. Owns the program counter, addresses a
// zero-latency single-port instruction memory by word and hands each fetched
// word to decode through a single valid/ready register slot. Taken branches
// and jumps arrive as redirects. A redirect to a target that is not word
// aligned parks the unit in an error state until an aligned redirect or reset.
//
// Optional feature (macro IFU_STALL_CNT_EN):
//   Adds output stall_cnt, a saturating count of cycles in which a valid
//   instruction was held because decode was not ready. It is cleared only by
//   rsta.
//
// Ports:
//   clka            clock, all state changes on the rising edge
//   rsta            synchronous active-high reset
//   mem_addr        word address to instruction memory (pc[ADDR_WIDTH+1:2])
//   mem_data        instruction word at mem_addr, valid in the same cycle
//   redirect_valid  a branch/jump is taken this cycle
//   redirect_pc     byte address of the redirect target
//   instr_valid     instr/instr_pc hold a fetched instruction
//   instr_ready     decode accepts instr this cycle
//   instr           fetched instruction
//   instr_pc        byte address of instr
//   misaligned      level, last redirect target had nonzero bits [1:0]
//   stall_cnt       (IFU_STALL_CNT_EN only) saturating stall cycle count
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clka,
    input  logic                  rsta,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [31:0]           instr_pc,
    output logic                  misaligned
`ifdef IFU_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // one settle cycle after reset, no capture
        RUN  = 2'd1,  // fetching
        ERR  = 2'd2   // parked after a misaligned redirect
    } state_e;

    state_e                  state_q;
    logic [31:0]             pc_q;
    logic                    instr_valid_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [31:0]             instr_pc_q;
    logic                    misaligned_q;

    logic [31:0]             pc_d;
    logic                    slot_free;
    logic                    target_misaligned;

    // PC wraps modulo 2^32; the memory only ever sees the word-index bits,
    // so high addresses alias onto the 2^ADDR_WIDTH-word memory.
    assign pc_d              = pc_q + 32'd4;
    assign slot_free         = !instr_valid_q || instr_ready;
    assign target_misaligned = |redirect_pc[1:0];

    assign mem_addr    = pc_q[ADDR_WIDTH+1:2];
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign misaligned  = misaligned_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            misaligned_q  <= 1'b0;
        end else if (redirect_valid) begin
            // A redirect beats capture and stall: the held word belongs to the
            // wrong path, so it is dropped even if decode never took it.
            instr_valid_q <= 1'b0;
            pc_q          <= redirect_pc;
            misaligned_q  <= target_misaligned;
            state_q       <= target_misaligned ? ERR : RUN;
        end else begin
            unique case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    // Capture whenever the slot is empty or being accepted this
                    // edge, which gives back-to-back delivery at full rate.
                    if (slot_free) begin
                        instr_q       <= mem_data;
                        instr_pc_q    <= pc_q;
                        instr_valid_q <= 1'b1;
                        pc_q          <= pc_d;
                    end
                end
                ERR: ;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef IFU_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clka) begin
        if (rsta) begin
            stall_cnt_q <= '0;
        end else if (instr_valid_q && !instr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. The instruction memory returns
// 32'hA000_0000 + word index. A reference model kept here tracks the fetch
// pointer and the single output slot from the documented rules; every cycle
// the DUT outputs are compared against it, and directed scenarios add
// explicit expectations on top. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_WIDTH = 9;
    localparam int unsigned DATA_WIDTH = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] MEM_BASE   = 32'hA000_0000;

    logic                  clka;
    logic                  rsta;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [31:0]           instr_pc;
    logic                  misaligned;
`ifdef IFU_STALL_CNT_EN
    logic [15:0]           stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] m_pc;      // next byte address to fetch
    bit          m_have;    // slot holds an undelivered instruction
    logic [31:0] m_word;
    logic [31:0] m_wpc;
    bit          m_err;     // parked after a misaligned target
    bit          m_warm;    // settle cycle after reset has elapsed
    int          m_stall;

    instr_fetch_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clka           (clka),
        .rsta           (rsta),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .misaligned     (misaligned)
`ifdef IFU_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    // Zero-latency memory: word k holds A000_0000 + k.
    assign mem_data = MEM_BASE + 32'(mem_addr);

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
        return MEM_BASE + ((byte_addr / 4) % 512);
    endfunction

    task automatic model_step(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        if (rst) begin
            m_pc = RESET_PC; m_have = 0; m_word = '0; m_wpc = '0;
            m_err = 0; m_warm = 0; m_stall = 0;
        end else begin
            if (m_have && !rdy && m_stall < 65535) m_stall++;
            if (rv) begin
                m_have = 0;
                m_pc   = rpc;
                m_err  = (rpc % 4) != 0;
                m_warm = 1;
            end else if (!m_warm) begin
                m_warm = 1;
            end else if (!m_err && (!m_have || rdy)) begin
                m_word = word_at(m_pc);
                m_wpc  = m_pc;
                m_have = 1;
                m_pc   = m_pc + 4;
            end
        end
    endtask

    task automatic compare_all();
        check("instr_valid", 32'(instr_valid), 32'(m_have));
        check("misaligned", 32'(misaligned), 32'(m_err));
        check("mem_addr", 32'(mem_addr), (m_pc / 4) % 512);
        if (m_have) begin
            check("instr", instr, m_word);
            check("instr_pc", instr_pc, m_wpc);
        end
`ifdef IFU_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        rsta           = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        @(posedge clka);
        model_step(rst, rv, rpc, rdy);
        #1;
        compare_all();
    endtask

    initial begin
        bit reached;
        rsta = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
        m_pc = RESET_PC; m_have = 0; m_word = '0; m_wpc = '0;
        m_err = 0; m_warm = 0; m_stall = 0;

        // Reset state.
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);

        // Release: settle cycle, then first capture.
        cycle(0, 0, 0, 1);
        check("e1_no_valid", 32'(instr_valid), 32'h0);
        cycle(0, 0, 0, 1);
        check("e2_valid", 32'(instr_valid), 32'h1);
        check("e2_instr", instr, 32'hA000_0000);

        // Stream until instr_pc == 8 (bounded).
        reached = 0;
        for (int i = 0; i < 10 && !reached; i++) begin
            cycle(0, 0, 0, 1);
            if (instr_valid && instr_pc == 32'h8) reached = 1;
        end
        check("reach_pc8", instr_pc, 32'h8);

        // Three stall cycles: output and fetch pointer hold.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            check("stall_instr", instr, 32'hA000_0002);
            check("stall_pc", instr_pc, 32'h8);
            check("stall_addr", 32'(mem_addr), 32'd3);
        end
`ifdef IFU_STALL_CNT_EN
        check("stall_cnt3", 32'(stall_cnt), 32'd3);
`endif
        cycle(0, 0, 0, 1);
        check("resume_instr", instr, 32'hA000_0003);
        check("resume_pc", instr_pc, 32'hC);

        // Redirect while stalled flushes the held word.
        cycle(0, 0, 0, 0);
        cycle(0, 1, 32'h100, 0);
        check("flush_valid", 32'(instr_valid), 32'h0);
        check("flush_addr", 32'(mem_addr), 32'h40);
        cycle(0, 0, 0, 1);
        check("tgt_pc", instr_pc, 32'h100);
        check("tgt_instr", instr, 32'hA000_0040);

        // Misaligned target parks the unit; aligned redirect recovers.
        cycle(0, 1, 32'h102, 1);
        check("mis_set", 32'(misaligned), 32'h1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 1);
            check("err_idle", 32'(instr_valid), 32'h0);
        end
        cycle(0, 1, 32'h20, 1);
        check("mis_clr", 32'(misaligned), 32'h0);
        check("bubble", 32'(instr_valid), 32'h0);
        cycle(0, 0, 0, 1);
        check("recover_pc", instr_pc, 32'h20);
        check("recover_instr", instr, 32'hA000_0008);

        // Word address wraps 511 -> 0.
        cycle(0, 1, 32'h7FC, 1);
        check("wrap_addr511", 32'(mem_addr), 32'd511);
        cycle(0, 0, 0, 1);
        check("wrap_pc7fc", instr_pc, 32'h7FC);
        check("wrap_instr1ff", instr, 32'hA000_01FF);
        check("wrap_addr0", 32'(mem_addr), 32'd0);
        cycle(0, 0, 0, 1);
        check("wrap_pc800", instr_pc, 32'h800);
        check("wrap_instr0", instr, 32'hA000_0000);

        // 32-bit PC wrap.
        cycle(0, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 0, 0, 1);
        check("pc32_top", instr_pc, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 1);
        check("pc32_wrap", instr_pc, 32'h0);

        // Reset beats a simultaneous redirect.
        cycle(1, 1, 32'h300, 1);
        check("rr_valid", 32'(instr_valid), 32'h0);
        check("rr_instr", instr, 32'h0);
        check("rr_pc", instr_pc, 32'h0);
        check("rr_addr", 32'(mem_addr), 32'(RESET_PC / 4));
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("rr_first", instr_pc, RESET_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst;
            bit          r_rv;
            bit          r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_rdy = ($urandom_range(0, 9) < 7);
            r_pc  = $urandom;
            if ($urandom_range(0, 3) == 0) r_pc[1:0] = 2'($urandom_range(1, 3));
            else                           r_pc[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) r_pc = r_pc & 32'h0000_0FFF;
            cycle(r_rst, r_rv, r_pc, r_rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
